// File: rtl/key_scan_ctrl_pkg.sv
// key_scan_ctrl_pkg: shared key matrix sizes, scan FSM states and priority helper
package key_scan_ctrl_pkg;
  localparam int NUM_COLS       = 4;
  localparam int NUM_ROWS       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int NUM_KEYS       = NUM_COLS * NUM_ROWS;
  localparam int KEY_IDX_W      = $clog2(NUM_KEYS);
  localparam int COL_W          = $clog2(NUM_COLS);
  localparam int CNT_W          = $clog2(DEBOUNCE_SCANS) + 1;

  typedef enum logic [1:0] {SCAN = 2'd0, UPDATE = 2'd1, ARB = 2'd2} scan_state_t;

  // Index of the highest set bit; 0 when nothing is set
  function automatic logic [KEY_IDX_W-1:0] highest_key(input logic [NUM_KEYS-1:0] keys);
    highest_key = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keys[i]) highest_key = KEY_IDX_W'(i);
  endfunction
endpackage

// File: rtl/key_scan_ctrl_debounce.sv
// key_debounce: one key's stable state, flipped after DEBOUNCE_SCANS disagreeing frames
module key_debounce
  import key_scan_ctrl_pkg::*;
(
  input  logic clk_100M,
  input  logic rst_n,
  input  logic raw,
  input  logic upd,
  output logic stable
);
  logic [CNT_W-1:0] cnt;
  // Count consecutive disagreeing frames; any agreeing frame restarts the count
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (upd) begin
      if (raw == stable) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        stable <= raw;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: scans the key matrix, debounces every key, reports the highest pressed key
module key_scan_ctrl
  import key_scan_ctrl_pkg::*;
(
  input  logic                 clk_100M,
  input  logic                 rst_n,
  input  logic                 tick_250,
  input  logic [NUM_ROWS-1:0]  row_n,
  output logic [NUM_COLS-1:0]  col_n,
  output logic [NUM_KEYS-1:0]  key_state,
  output logic                 note_valid,
  output logic [KEY_IDX_W-1:0] note_idx,
  output logic                 note_event
);
  logic [NUM_ROWS-1:0]  row_meta, row_sync;
  logic [COL_W-1:0]     col_ptr;
  logic [NUM_KEYS-1:0]  raw;
  logic                 pending, fire, last_col, upd, any_key;
  logic [KEY_IDX_W-1:0] cand;
  scan_state_t          state, state_nxt;

  assign fire     = (state == SCAN) && (tick_250 || pending);
  assign last_col = col_ptr == COL_W'(NUM_COLS - 1);
  assign col_n    = ~(NUM_COLS'(1) << col_ptr);
  assign any_key  = |key_state;
  assign cand     = highest_key(key_state);

  // Two-flop synchroniser for the asynchronous row pins, idle high
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end

  // Scan state register
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) state <= SCAN;
    else state <= state_nxt;

  // Next state: a full frame of column samples triggers one debounce and one arbitration cycle
  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    unique case (state)
      SCAN:    state_nxt = (fire && last_col) ? UPDATE : SCAN;
      UPDATE: begin
        state_nxt = ARB;
        upd       = 1'b1;
      end
      ARB:     state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // Sample the driven column, advance it, and remember ticks that arrive outside SCAN
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) begin
      raw     <= '0;
      col_ptr <= '0;
      pending <= 1'b0;
    end else begin
      pending <= (state != SCAN) ? (pending | tick_250) : 1'b0;
      if (fire) begin
        raw[col_ptr*NUM_ROWS +: NUM_ROWS] <= ~row_sync;
        col_ptr <= last_col ? '0 : col_ptr + 1'b1;
      end
    end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce u_db (
      .clk_100M (clk_100M),
      .rst_n    (rst_n),
      .raw      (raw[k]),
      .upd      (upd),
      .stable   (key_state[k])
    );
  end

  // Arbitrate to the highest pressed key; idx holds while nothing is pressed
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) begin
      note_valid <= 1'b0;
      note_idx   <= '0;
      note_event <= 1'b0;
    end else if (state == ARB) begin
      note_valid <= any_key;
      if (any_key) note_idx <= cand;
      note_event <= (any_key != note_valid) || (any_key && cand != note_idx);
    end else note_event <= 1'b0;
endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: table, directed and randomized checks of key_scan_ctrl
module tb_key_scan_ctrl;
  import key_scan_ctrl_pkg::*;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        tick_250 = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] key_state;
  logic        note_valid;
  logic [3:0]  note_idx;
  logic        note_event;
  logic [15:0] keys = '0;
  int          n_chk = 0, n_fail = 0, ev_cnt = 0, e0;

  key_scan_ctrl dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .tick_250   (tick_250),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_state  (key_state),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .note_event (note_event)
  );

  always #5 clk_100M = ~clk_100M;

  always @(posedge clk_100M) if (note_event) ev_cnt <= ev_cnt + 1;

  // Physical keypad: a pressed key shorts its column to its row
  always_comb begin
    row_n = '1;
    for (int c = 0; c < 4; c++)
      if (!col_n[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row_n[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    logic [15:0] ks;
    logic        valid;
    logic [3:0]  idx;
    int          ev;
  } vec_t;
  vec_t tbl[17];

  // Reference model: per-key count of consecutive frames disagreeing with the stable level
  logic [15:0] m_stable;
  int          m_run[16];
  logic        m_valid;
  logic [3:0]  m_idx;
  int          m_ev;

  task automatic model_reset();
    m_stable = '0;
    m_valid  = 1'b0;
    m_idx    = '0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int top;
    for (int i = 0; i < 16; i++) begin
      m_run[i] = (k[i] == m_stable[i]) ? 0 : m_run[i] + 1;
      if (m_run[i] >= DEBOUNCE_SCANS) begin
        m_stable[i] = k[i];
        m_run[i]    = 0;
      end
    end
    top = -1;
    for (int i = 0; i < 16; i++) if (m_stable[i]) top = i;
    m_ev = ((top >= 0) != m_valid || (top >= 0 && top != int'(m_idx))) ? 1 : 0;
    m_valid = top >= 0;
    if (top >= 0) m_idx = 4'(top);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_tick(input int gap);
    repeat (gap - 1) @(negedge clk_100M);
    tick_250 = 1'b1;
    @(negedge clk_100M);
    tick_250 = 1'b0;
  endtask

  task automatic frame(input logic [15:0] k, input int gap);
    keys = k;
    for (int c = 0; c < 4; c++) do_tick(gap);
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic check_frame(input string name, input logic [15:0] k, input logic [15:0] ks,
                             input logic v, input logic [3:0] idx, input int ev, input int gap);
    int e;
    e = ev_cnt;
    frame(k, gap);
    chk({name, " key_state"}, 32'(key_state), 32'(ks));
    chk({name, " note_valid"}, 32'(note_valid), 32'(v));
    chk({name, " note_idx"}, 32'(note_idx), 32'(idx));
    chk({name, " events"}, 32'(ev_cnt - e), 32'(ev));
  endtask

  task automatic do_reset();
    @(negedge clk_100M);
    rst_n = 1'b0;
    keys  = '0;
    repeat (2) @(negedge clk_100M);
    rst_n = 1'b1;
    @(negedge clk_100M);
  endtask

  initial begin
    logic [15:0] k;
    logic [3:0]  ecol;
    tbl[0]  = '{16'h0020, 16'h0000, 1'b0, 4'd0, 0};
    tbl[1]  = '{16'h0020, 16'h0020, 1'b1, 4'd5, 1};
    tbl[2]  = '{16'h0020, 16'h0020, 1'b1, 4'd5, 0};
    tbl[3]  = '{16'h0000, 16'h0020, 1'b1, 4'd5, 0};
    tbl[4]  = '{16'h0000, 16'h0000, 1'b0, 4'd5, 1};
    tbl[5]  = '{16'h0020, 16'h0000, 1'b0, 4'd5, 0};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 4'd5, 0};
    tbl[7]  = '{16'h0020, 16'h0000, 1'b0, 4'd5, 0};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 4'd5, 0};
    tbl[9]  = '{16'h0020, 16'h0000, 1'b0, 4'd5, 0};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 4'd5, 0};
    tbl[11] = '{16'h1008, 16'h0000, 1'b0, 4'd5, 0};
    tbl[12] = '{16'h1008, 16'h1008, 1'b1, 4'd12, 1};
    tbl[13] = '{16'h0008, 16'h1008, 1'b1, 4'd12, 0};
    tbl[14] = '{16'h0008, 16'h0008, 1'b1, 4'd3, 1};
    tbl[15] = '{16'h0000, 16'h0008, 1'b1, 4'd3, 0};
    tbl[16] = '{16'h0000, 16'h0000, 1'b0, 4'd3, 1};

    #2;
    chk("reset col_n", 32'(col_n), 32'h0000000E);
    chk("reset key_state", 32'(key_state), 32'h0);
    chk("reset note_valid", 32'(note_valid), 32'h0);
    chk("reset note_idx", 32'(note_idx), 32'h0);
    chk("reset note_event", 32'(note_event), 32'h0);
    repeat (3) @(negedge clk_100M);
    rst_n = 1'b1;
    e0 = ev_cnt;
    repeat (5) @(negedge clk_100M);
    chk("reset release event", 32'(ev_cnt - e0), 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_tick(6);
      ecol = ~(4'b0001 << ((i + 1) % 4));
      chk("scan order col_n", 32'(col_n), 32'(ecol));
    end
    repeat (3) @(negedge clk_100M);
    chk("scan order no event", 32'(ev_cnt - e0), 32'h0);

    do_reset();
    for (int i = 0; i < 17; i++)
      check_frame($sformatf("vec%0d", i), tbl[i].keys, tbl[i].ks, tbl[i].valid, tbl[i].idx, tbl[i].ev, 8);

    do_reset();
    check_frame("forced pre", 16'h0020, 16'h0000, 1'b0, 4'd0, 0, 8);
    for (int c = 0; c < 4; c++) do_tick(8);
    tick_250 = 1'b1;
    @(negedge clk_100M);
    tick_250 = 1'b0;
    repeat (2) @(negedge clk_100M);
    chk("pending tick col_n", 32'(col_n), 32'h0000000D);
    chk("pending tick key_state", 32'(key_state), 32'h00000020);
    for (int c = 0; c < 3; c++) do_tick(8);
    repeat (3) @(negedge clk_100M);
    chk("pending frame col_n", 32'(col_n), 32'h0000000E);
    chk("pending frame note_idx", 32'(note_idx), 32'h5);
    chk("pending frame note_valid", 32'(note_valid), 32'h1);

    do_tick(8);
    do_tick(8);
    @(negedge clk_100M);
    rst_n = 1'b0;
    #1;
    chk("midreset key_state", 32'(key_state), 32'h0);
    chk("midreset note_valid", 32'(note_valid), 32'h0);
    chk("midreset note_idx", 32'(note_idx), 32'h0);
    chk("midreset col_n", 32'(col_n), 32'h0000000E);
    repeat (2) @(negedge clk_100M);
    rst_n = 1'b1;
    check_frame("midreset f1", 16'h0020, 16'h0000, 1'b0, 4'd0, 0, 8);
    check_frame("midreset f2", 16'h0020, 16'h0020, 1'b1, 4'd5, 1, 8);

    do_reset();
    model_reset();
    k = '0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 1) k = 16'($urandom & $urandom);
      model_frame(k);
      check_frame($sformatf("rand%0d", f), k, m_stable, m_valid, m_idx, m_ev, int'($urandom_range(3, 10)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
